// File: rtl/philv_pkg.sv
// ----------------------------------------------------------------------------
// philv_pkg
//   Shared definitions for the PhilosophyV core.
//   - XLEN / REG_ADDR_W : architectural data and register-address widths
//   - REG_ZERO          : address of the hardwired-zero register (x0)
//   - xlen_t, reg_addr_t: convenience data / register-address types
//   - rf_state_t        : register-file init sequencer states
// ----------------------------------------------------------------------------
package philv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    typedef enum logic {
        RF_INIT,
        RF_READY
    } rf_state_t;

endpackage

// File: rtl/regfile_init_ctrl.sv
// ----------------------------------------------------------------------------
// regfile_init_ctrl
//   Post-reset sweep sequencer for the register file. After reset it walks
//   init_ptr from 1 up to NUM_REGS-1, one entry per cycle, requesting a zero
//   write to each entry, then parks in RF_READY until the next reset.
//
// Ports
//   clk      in   clock, all state updates on posedge
//   rst      in   asynchronous active-low reset
//   busy     out  high while the sweep runs (registered)
//   init_we  out  sweep write strobe
//   init_wa  out  sweep write address (current init_ptr)
// ----------------------------------------------------------------------------
module regfile_init_ctrl
    import philv_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_wa
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    rf_state_t         state;
    logic [ADDR_W-1:0] init_ptr;

    // Entry 0 is never swept: it is hardwired to zero on the read side.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RF_INIT;
            init_ptr <= ADDR_W'(1);
            busy     <= 1'b1;
        end else begin
            case (state)
                RF_INIT: begin
                    init_ptr <= init_ptr + ADDR_W'(1);
                    // Last entry is written on this edge; busy drops with it.
                    if (init_ptr == LAST_ADDR) begin
                        state <= RF_READY;
                        busy  <= 1'b0;
                    end
                end
                RF_READY: begin
                    // Idle until the next reset restarts the sweep.
                end
                default: begin
                    state <= RF_INIT;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    assign init_we = (state == RF_INIT);
    assign init_wa = init_ptr;

endmodule

// File: rtl/regfile.sv
// ----------------------------------------------------------------------------
// regfile
//   Architectural integer register file: one write port (write-back stage),
//   two registered read ports (decode stage). Entry 0 reads as zero. After
//   reset an init sweep clears entries 1..NUM_REGS-1, one per cycle; reads and
//   writes are ignored while busy is high. The array itself has no reset so it
//   can map onto distributed RAM.
//
// Ports
//   clk       in   clock, all state updates on posedge
//   rst       in   asynchronous active-low reset
//   busy      out  high while the init sweep runs
//   we        in   write enable
//   wa        in   write address
//   wd        in   write data
//   rd_ena    in   read request, samples ra1/ra2
//   ra1, ra2  in   read addresses
//   rd1, rd2  out  registered read data, valid when rd_valid=1
//   rd_valid  out  one-cycle pulse after an accepted rd_ena
//
// Configuration
//   REGFILE_DEBUG_PORT_EN : when defined, adds dbg_addr (in) and dbg_data
//   (out), a combinational third read path with no write bypass.
// ----------------------------------------------------------------------------
module regfile
    import philv_pkg::*;
#(
    parameter int N        = XLEN,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [N-1:0]      wd,
    input  logic              rd_ena,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [N-1:0]      rd1,
    output logic [N-1:0]      rd2,
    output logic              rd_valid
`ifdef REGFILE_DEBUG_PORT_EN
    ,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [N-1:0]      dbg_data
`endif
);

    logic [N-1:0] mem [NUM_REGS];

    logic              init_we;
    logic [ADDR_W-1:0] init_wa;

    regfile_init_ctrl #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_init_ctrl (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy),
        .init_we (init_we),
        .init_wa (init_wa)
    );

    // ------------------------------------------------------------------
    // Write port: the sweep owns it while busy; afterwards the user port,
    // with writes to entry 0 discarded.
    // ------------------------------------------------------------------
    logic              usr_we;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [N-1:0]      wdata;

    assign usr_we = !busy && we && (wa != '0);
    assign wen    = init_we || usr_we;
    assign waddr  = init_we ? init_wa : wa;
    assign wdata  = init_we ? '0      : wd;

    // NOTE: the storage array is deliberately left without a reset; a reset
    // would stop it mapping to RAM, and the sweep defines its contents.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read ports: x0 reads zero, otherwise a same-cycle write to the same
    // address is forwarded (write-first), otherwise the stored value.
    // ------------------------------------------------------------------
    logic [N-1:0] rd1_next;
    logic [N-1:0] rd2_next;
    logic         rd_accept;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rd1_next = '0;
        rd2_next = '0;
        if (ra1 != '0) begin
            rd1_next = (usr_we && (wa == ra1)) ? wd : mem[ra1];
        end
        if (ra2 != '0) begin
            rd2_next = (usr_we && (wa == ra2)) ? wd : mem[ra2];
        end
    end

    assign rd_accept = rd_ena && !busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd1      <= '0;
            rd2      <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) begin
                rd1 <= rd1_next;
                rd2 <= rd2_next;
            end
        end
    end

`ifdef REGFILE_DEBUG_PORT_EN
    // Observation port: raw array contents, no bypass, valid in all states.
    assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
`endif

endmodule

// File: tb/tb_regfile.sv
// ----------------------------------------------------------------------------
// tb_regfile
//   Scoreboarded bench for regfile. The stimulus process drives one
//   transaction per cycle and, from a plain array model of the architectural
//   registers, pushes the expected read response into a queue. A separate
//   monitor pops and compares whenever rd_valid is high.
// ----------------------------------------------------------------------------
module tb_regfile;
    import philv_pkg::*;

    localparam int NUM_REGS = 32;
    localparam int SWEEP    = NUM_REGS - 1;
    localparam int PERIOD   = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busy;
    logic        we = 1'b0;
    reg_addr_t   wa = '0;
    xlen_t       wd = '0;
    logic        rd_ena = 1'b0;
    reg_addr_t   ra1 = '0;
    reg_addr_t   ra2 = '0;
    xlen_t       rd1;
    xlen_t       rd2;
    logic        rd_valid;
`ifdef REGFILE_DEBUG_PORT_EN
    reg_addr_t   dbg_addr = '0;
    xlen_t       dbg_data;
`endif

    always #(PERIOD/2) clk = ~clk;

    regfile dut (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .rd_ena   (rd_ena),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .rd_valid (rd_valid)
`ifdef REGFILE_DEBUG_PORT_EN
        ,
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`endif
    );

    // ---------------- scoreboard state ----------------
    typedef struct {
        xlen_t  d1;
        xlen_t  d2;
        longint t_issue;
    } exp_t;

    exp_t  exp_q[$];
    xlen_t model_mem [NUM_REGS];
    int    init_left = SWEEP;
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural view of a read: x0 is zero, a same-cycle write wins.
    function automatic xlen_t model_read(input reg_addr_t ra, input logic w,
                                         input reg_addr_t a, input xlen_t d);
        if (ra == 0) return '0;
        if (w && a == ra) return d;
        return model_mem[ra];
    endfunction

    // One transaction; called at a negedge, returns at the next negedge.
    task automatic do_cycle(input logic w, input reg_addr_t a, input xlen_t d,
                            input logic r, input reg_addr_t a1, input reg_addr_t a2);
        check("busy", 32'(busy), 32'(init_left > 0));
        we = w; wa = a; wd = d; rd_ena = r; ra1 = a1; ra2 = a2;
        if (init_left > 0) begin
            init_left--;
        end else begin
            if (r) begin
                exp_t e;
                e.d1 = model_read(a1, w, a, d);
                e.d2 = model_read(a2, w, a, d);
                e.t_issue = $time;
                exp_q.push_back(e);
            end
            if (w && a != 0) model_mem[a] = d;
        end
        @(negedge clk);
        we = 1'b0; rd_ena = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Called at a negedge: asserts reset (after the monitor has sampled),
    // holds it n cycles with traffic that must be ignored, releases at a negedge.
    task automatic apply_reset(input int n);
        #2;
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NUM_REGS; i++) model_mem[i] = '0;
        we = 1'b1; wa = 5'd4; wd = 32'hCAFE_F00D; rd_ena = 1'b1; ra1 = 5'd4; ra2 = 5'd5;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_busy", 32'(busy), 32'd1);
            check("rst_rd_valid", 32'(rd_valid), 32'd0);
            check("rst_rd1", rd1, 32'd0);
        end
        we = 1'b0; rd_ena = 1'b0;
        rst = 1'b1;
        init_left = SWEEP;
    endtask

    // Counts cycles with busy high, starting at the release negedge.
    task automatic count_busy(input string name);
        int cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check(name, 32'(cnt), 32'(SWEEP));
        init_left = 0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rd_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rd1", rd1, e.d1);
                check("rd2", rd2, e.d2);
                check("rd_latency", 32'($time - e.t_issue), 32'(PERIOD));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < NUM_REGS; i++) model_mem[i] = '0;

        // Reset state, with a read request that must not be accepted.
        rd_ena = 1'b1;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd1", rd1, 32'd0);
        check("reset_rd2", rd2, 32'd0);
        rd_ena = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // 1. Sweep length, then every entry reads zero on both ports.
        count_busy("busy_cycles_initial");
        for (int a = 0; a < NUM_REGS; a++)
            do_cycle(1'b0, '0, '0, 1'b1, reg_addr_t'(a), reg_addr_t'(NUM_REGS - 1 - a));

        // 2. Write then read.
        do_cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0);
        do_cycle(1'b0, '0, '0, 1'b1, 5'd5, 5'd0);

        // 3. Same-cycle write/read bypass on both ports.
        do_cycle(1'b1, 5'd7, 32'h1234_5678, 1'b1, 5'd7, 5'd7);
        do_cycle(1'b0, '0, '0, 1'b1, 5'd7, 5'd5);

        // 4a. Writes to x0 are discarded, including the bypass path.
        do_cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0);
        do_cycle(1'b0, '0, '0, 1'b1, 5'd0, 5'd7);

        // 4b. Traffic during INIT is ignored.
        apply_reset(2);
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 5'd3, 32'd1, 1'b1, 5'd3, 5'd3);
        while (init_left > 0) idle(1);
        do_cycle(1'b0, '0, '0, 1'b1, 5'd3, 5'd5);

        // 5. Reset at sweep cycle 10 restarts the full sweep and clears data.
        do_cycle(1'b1, 5'd5, 32'h5555_AAAA, 1'b0, '0, '0);
        do_cycle(1'b0, '0, '0, 1'b1, 5'd5, 5'd5);
        apply_reset(2);
        for (int i = 0; i < 10; i++) do_cycle(1'b1, 5'd5, 32'h0BAD_0BAD, 1'b1, 5'd5, 5'd6);
        apply_reset(3);
        count_busy("busy_cycles_after_midsweep_reset");
        do_cycle(1'b0, '0, '0, 1'b1, 5'd5, 5'd1);

        // Randomized traffic, biased to a small address window for collisions.
        for (int i = 0; i < 400; i++) begin
            logic      w, r;
            reg_addr_t a, a1, a2;
            logic      narrow;
            narrow = ($urandom_range(0, 1) == 0);
            w  = ($urandom_range(0, 2) != 0);
            r  = ($urandom_range(0, 2) != 0);
            a  = narrow ? reg_addr_t'($urandom_range(0, 3)) : reg_addr_t'($urandom_range(0, NUM_REGS - 1));
            a1 = narrow ? reg_addr_t'($urandom_range(0, 3)) : reg_addr_t'($urandom_range(0, NUM_REGS - 1));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : reg_addr_t'($urandom_range(0, NUM_REGS - 1));
            do_cycle(w, a, xlen_t'($urandom), r, a1, a2);
        end

`ifdef REGFILE_DEBUG_PORT_EN
        // 6. Debug port shows the written value right after the write edge.
        do_cycle(1'b1, 5'd9, 32'hA5A5_A5A5, 1'b0, '0, '0);
        dbg_addr = 5'd9;
        #1;
        check("dbg_entry9", dbg_data, 32'hA5A5_A5A5);
        for (int a = 0; a < NUM_REGS; a++) begin
            dbg_addr = reg_addr_t'(a);
            #1;
            check("dbg_sweep", dbg_data, (a == 0) ? 32'd0 : model_mem[a]);
        end
        @(negedge clk);
`endif

        idle(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(PERIOD * 20000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
